// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: data-memory bus between the MEM-stage unit and the memory
//   master: drives DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA; receives DM_RDATA, DM_ACK
//   slave : the reverse
interface dmem_access_unit_if;
  logic        DM_REQ, DM_WE, DM_ACK;
  logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
  logic [3:0]  DM_BE;
  modport master(output DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA, input DM_RDATA, DM_ACK);
  modport slave(input DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA, output DM_RDATA, DM_ACK);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory responder (handshake, store lane steering, load extension)
//   CLK, RST (sync, active-high); EX/MEM request: ALU_VAL_EM, STORE_VAL_EM, MemRead_EM, MemWrite_EM, DMSE_EM
//   bus: dmem_access_unit_if.master; results: LOAD_VAL_MW, STALL, MISALIGN, BUS_ERR
//   Optional DMEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT_CYC cycles without DM_ACK.
module dmem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               ALU_VAL_EM,
  input  logic [31:0]               STORE_VAL_EM,
  input  logic [1:0]                MemRead_EM,
  input  logic [1:0]                MemWrite_EM,
  input  logic                      DMSE_EM,
  dmem_access_unit_if.master        bus,
  output logic [31:0]               LOAD_VAL_MW,
  output logic                      STALL,
  output logic                      MISALIGN,
  output logic                      BUS_ERR
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic        rd, req, mis;
  logic [1:0]  sz;
  logic [3:0]  be;
  logic [31:0] wd, ext;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        req_q, req_d, we_q, we_d, mis_q, mis_d, err_q, err_d, se_q, se_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d, sz_q, sz_d;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  // a read and a write in the same request: the read wins
  assign rd  = |MemRead_EM;
  assign req = rd | |MemWrite_EM;
  assign sz  = rd ? MemRead_EM : MemWrite_EM;
  assign mis = (sz == 2'b10 && ALU_VAL_EM[0]) || (sz == 2'b11 && |ALU_VAL_EM[1:0]);
  assign be  = sz == 2'b01 ? 4'b0001 << ALU_VAL_EM[1:0] :
               sz == 2'b10 ? (ALU_VAL_EM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd  = sz == 2'b01 ? {4{STORE_VAL_EM[7:0]}} :
               sz == 2'b10 ? {2{STORE_VAL_EM[15:0]}} : STORE_VAL_EM;
  // lane, size and sign mode are latched at issue so extraction does not depend on EX/MEM timing
  assign lb  = bus.DM_RDATA[8*lane_q +: 8];
  assign lh  = lane_q[1] ? bus.DM_RDATA[31:16] : bus.DM_RDATA[15:0];
  assign ext = sz_q == 2'b01 ? {{24{se_q & lb[7]}}, lb} :
               sz_q == 2'b10 ? {{16{se_q & lh[15]}}, lh} : bus.DM_RDATA;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    lane_d  = lane_q;
    sz_d    = sz_q;
    se_d    = se_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (req && mis) begin
        mis_d  = 1'b1;
        load_d = '0;
      end else if (req) begin
        state_d = BUSY;
        req_d   = 1'b1;
        we_d    = !rd;
        addr_d  = {ALU_VAL_EM[31:2], 2'b00};
        be_d    = be;
        wdata_d = wd;
        lane_d  = ALU_VAL_EM[1:0];
        sz_d    = sz;
        se_d    = DMSE_EM;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: if (bus.DM_ACK) begin
        state_d = DONE;
        req_d   = 1'b0;
        load_d  = we_q ? load_q : ext;
      end
`ifdef DMEM_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d = DONE;
        req_d   = 1'b0;
        load_d  = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      lane_q  <= '0;
      sz_q    <= '0;
      se_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      lane_q  <= lane_d;
      sz_q    <= sz_d;
      se_q    <= se_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  // STALL depends only on state and EX/MEM inputs, never on DM_ACK
  assign STALL        = !RST && (state_q == BUSY || (state_q == IDLE && req && !mis));
  assign bus.DM_REQ   = req_q;
  assign bus.DM_WE    = we_q;
  assign bus.DM_ADDR  = addr_q;
  assign bus.DM_BE    = be_q;
  assign bus.DM_WDATA = wdata_q;
  assign LOAD_VAL_MW  = load_q;
  assign MISALIGN     = mis_q;
  assign BUS_ERR      = err_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed-vector bench for dmem_access_unit
module tb_dmem_access_unit;
`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic        clk = 1'b0, rst = 1'b1, dmse = 1'b0;
  logic [31:0] alu = '0, sval = '0, load;
  logic [1:0]  mread = '0, mwrite = '0;
  logic        stall, misalign, bus_err;
  int          vecs = 0, errs = 0, stalls;
  logic        c_req, c_we, d_stall, d_req;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  dmem_access_unit_if bus();
  dmem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RST(rst), .ALU_VAL_EM(alu), .STORE_VAL_EM(sval), .MemRead_EM(mread),
    .MemWrite_EM(mwrite), .DMSE_EM(dmse), .bus(bus), .LOAD_VAL_MW(load), .STALL(stall),
    .MISALIGN(misalign), .BUS_ERR(bus_err)
  );
  always #5 clk = ~clk;
  initial begin
    bus.DM_ACK = 1'b0;
    bus.DM_RDATA = '0;
  end

  task automatic access(input logic [31:0] a, sd, rdat, input logic [1:0] r, w, input logic se, input int nbusy);
    alu = a; sval = sd; mread = r; mwrite = w; dmse = se; stalls = 0;
    for (int i = 0; i <= nbusy; i++) begin
      if (i == nbusy) begin bus.DM_ACK = 1'b1; bus.DM_RDATA = rdat; end
      #1;
      if (stall) stalls++;
      @(negedge clk);
      if (i == 0) begin
        c_req = bus.DM_REQ; c_we = bus.DM_WE; c_addr = bus.DM_ADDR; c_be = bus.DM_BE; c_wdata = bus.DM_WDATA;
      end
    end
    bus.DM_ACK = 1'b0;
    #1;
    d_stall = stall; d_req = bus.DM_REQ;
    mread = '0; mwrite = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.DM_REQ !== 1'b0) begin errs++; $display("FAIL rst_req got %b exp 0", bus.DM_REQ); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b exp 0", stall); end
    vecs++; if (load !== 32'h0) begin errs++; $display("FAIL rst_load got %h exp 0", load); end
    vecs++; if ({misalign, bus_err, bus.DM_WE, bus.DM_BE} !== 7'h0) begin errs++; $display("FAIL rst_misc got %b exp 0", {misalign, bus_err, bus.DM_WE, bus.DM_BE}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    access(32'h100, 32'h0, 32'h8000_00FF, 2'b11, 2'b00, 1'b1, 3);
    vecs++; if (c_req !== 1'b1 || c_we !== 1'b0) begin errs++; $display("FAIL lw_req_we got %b%b exp 10", c_req, c_we); end
    vecs++; if (c_addr !== 32'h100) begin errs++; $display("FAIL lw_addr got %h exp 100", c_addr); end
    vecs++; if (c_be !== 4'b1111) begin errs++; $display("FAIL lw_be got %b exp 1111", c_be); end
    vecs++; if (stalls !== 4) begin errs++; $display("FAIL lw_stall_cycles got %0d exp 4", stalls); end
    vecs++; if (d_stall !== 1'b0 || d_req !== 1'b0) begin errs++; $display("FAIL lw_done got %b%b exp 00", d_stall, d_req); end
    vecs++; if (load !== 32'h8000_00FF) begin errs++; $display("FAIL lw_load got %h exp 800000ff", load); end
  endtask

  task automatic test_byte_half_loads();
    access(32'h103, 32'h0, 32'h8012_3456, 2'b01, 2'b00, 1'b1, 1);
    vecs++; if (c_be !== 4'b1000) begin errs++; $display("FAIL lb_be got %b exp 1000", c_be); end
    vecs++; if (stalls !== 2) begin errs++; $display("FAIL lb_stall_cycles got %0d exp 2", stalls); end
    vecs++; if (load !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_load got %h exp ffffff80", load); end
    access(32'h103, 32'h0, 32'h8012_3456, 2'b01, 2'b00, 1'b0, 1);
    vecs++; if (load !== 32'h0000_0080) begin errs++; $display("FAIL lbu_load got %h exp 00000080", load); end
    access(32'h102, 32'h0, 32'h8001_1234, 2'b10, 2'b00, 1'b1, 2);
    vecs++; if (c_be !== 4'b1100) begin errs++; $display("FAIL lh_be got %b exp 1100", c_be); end
    vecs++; if (load !== 32'hFFFF_8001) begin errs++; $display("FAIL lh_load got %h exp ffff8001", load); end
    access(32'h100, 32'h0, 32'h1234_F00D, 2'b10, 2'b00, 1'b0, 1);
    vecs++; if (load !== 32'h0000_F00D) begin errs++; $display("FAIL lhu_load got %h exp 0000f00d", load); end
    access(32'h101, 32'h5555_5555, 32'hAA55_C37E, 2'b01, 2'b11, 1'b1, 1);
    vecs++; if (c_we !== 1'b0 || c_be !== 4'b0010) begin errs++; $display("FAIL rd_wins got we=%b be=%b exp we=0 be=0010", c_we, c_be); end
    vecs++; if (load !== 32'hFFFF_FFC3) begin errs++; $display("FAIL rd_wins_load got %h exp ffffffc3", load); end
  endtask

  task automatic test_stores();
    access(32'h22, 32'h1234_ABCD, 32'hFFFF_FFFF, 2'b00, 2'b10, 1'b0, 1);
    vecs++; if (c_we !== 1'b1 || c_addr !== 32'h20) begin errs++; $display("FAIL sh_we_addr got %b %h exp 1 00000020", c_we, c_addr); end
    vecs++; if (c_be !== 4'b1100) begin errs++; $display("FAIL sh_be got %b exp 1100", c_be); end
    vecs++; if (c_wdata !== 32'hABCD_ABCD) begin errs++; $display("FAIL sh_wdata got %h exp abcdabcd", c_wdata); end
    vecs++; if (load !== 32'hFFFF_FFC3) begin errs++; $display("FAIL sh_load_kept got %h exp ffffffc3", load); end
    access(32'h21, 32'h0000_00EF, 32'h0, 2'b00, 2'b01, 1'b0, 2);
    vecs++; if (c_be !== 4'b0010 || c_wdata !== 32'hEFEF_EFEF) begin errs++; $display("FAIL sb got be=%b wd=%h exp 0010 efefefef", c_be, c_wdata); end
    access(32'h44, 32'hCAFE_F00D, 32'h0, 2'b00, 2'b11, 1'b0, 1);
    vecs++; if (c_be !== 4'b1111 || c_wdata !== 32'hCAFE_F00D || c_addr !== 32'h44) begin errs++; $display("FAIL sw got be=%b wd=%h a=%h exp 1111 cafef00d 44", c_be, c_wdata, c_addr); end
  endtask

  task automatic test_misalign();
    alu = 32'h102; mread = 2'b11; dmse = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL mis_stall got %b exp 0", stall); end
    @(negedge clk);
    vecs++; if (misalign !== 1'b1 || bus.DM_REQ !== 1'b0) begin errs++; $display("FAIL mis_pulse got mis=%b req=%b exp 1 0", misalign, bus.DM_REQ); end
    vecs++; if (load !== 32'h0) begin errs++; $display("FAIL mis_load got %h exp 0", load); end
    mread = '0;
    @(negedge clk);
    vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL mis_one_cycle got %b exp 0", misalign); end
  endtask

  task automatic test_reset_in_busy();
    access(32'h100, 32'h0, 32'h1122_3344, 2'b11, 2'b00, 1'b0, 1);
    vecs++; if (load !== 32'h1122_3344) begin errs++; $display("FAIL pre_rst_load got %h exp 11223344", load); end
    alu = 32'h100; mread = 2'b11;
    @(negedge clk);
    rst = 1'b1; bus.DM_ACK = 1'b1; bus.DM_RDATA = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.DM_ACK = 1'b0;
    vecs++; if (bus.DM_REQ !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL rst_busy got req=%b stall=%b exp 0 0", bus.DM_REQ, stall); end
    vecs++; if (load !== 32'h0) begin errs++; $display("FAIL rst_busy_load got %h exp 0", load); end
    rst = 1'b0; mread = '0;
    @(negedge clk);
    vecs++; if (bus.DM_REQ !== 1'b0 || load !== 32'h0) begin errs++; $display("FAIL rst_busy_idle got req=%b load=%h exp 0 0", bus.DM_REQ, load); end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    alu = 32'h200; mread = 2'b11;
    while (bus_err !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vecs++; if (n !== 5) begin errs++; $display("FAIL to_cycles got %0d exp 5", n); end
    vecs++; if (load !== 32'h0 || stall !== 1'b0 || bus.DM_REQ !== 1'b0) begin errs++; $display("FAIL to_done got load=%h stall=%b req=%b exp 0 0 0", load, stall, bus.DM_REQ); end
    mread = '0;
    @(negedge clk);
    vecs++; if (bus_err !== 1'b0) begin errs++; $display("FAIL to_pulse got %b exp 0", bus_err); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_misalign();
    test_reset_in_busy();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
